el2_lsu_addrcheck_prog: RTL and testbench
=========================================

Name: el2_lsu_addrcheck_prog

Overview:
- Programmable, pipelined successor to the fixed LSU memory-map checker.
- Replaces elaboration-time data-access windows with NUM_REGIONS runtime-configured regions. Each region has a base, a mask, read/write/side-effect attributes and a sticky lock.
- Checks the start and end address of each D-stage request and registers the verdict into M.
- Holds a first-fault capture record for debug/trap handlers.

Parameters:
- NUM_REGIONS, 8, number of programmable regions (1..16).
- ADDR_WIDTH, 32, address width; region select is the top 4 bits.
- CNT_WIDTH, 16, width of the optional fault counter.

Ports:
- clk  in  1  core clock
- rst_l  in  1  asynchronous active-low reset
- cfg_wr_en  in  1  region config write strobe
- cfg_idx  in  4  region index; writes to index >= NUM_REGIONS are ignored
- cfg_sel  in  2  field select: 0 base, 1 mask, 2 attr, 3 reserved (ignored)
- cfg_wdata  in  ADDR_WIDTH  write data; attr field uses bits [0]=en, [1]=R, [2]=W, [3]=side-effect, [7]=lock
- d_valid  in  1  request valid in D
- d_ready  out  1  request accepted; equals ~m_stall
- d_start_addr  in  ADDR_WIDTH  first byte address
- d_end_addr  in  ADDR_WIDTH  last byte address
- d_size  in  2  access size: 0 byte, 1 half, 2 word (3 is treated as word)
- d_load  in  1  load
- d_store  in  1  store
- d_dma  in  1  DMA request; faults suppressed
- m_stall  in  1  hold the M stage
- m_valid  out  1  M result valid
- m_access_fault  out  1  access fault
- m_misaligned_fault  out  1  misaligned fault
- m_mscause  out  4  fault cause
- m_sideeffect  out  1  access targets a side-effect region
- m_region_idx  out  4  region matched by the start address
- fault_valid  out  1  capture record holds a fault
- fault_addr  out  ADDR_WIDTH  captured start address
- fault_cause  out  4  captured mscause
- fault_clr  in  1  clear the capture record

Behaviour:
- Reset values:
  - All region registers are 0 (disabled, unlocked).
  - All M outputs are 0.
  - fault_valid=0, fault_addr=0, fault_cause=0.
  - Optional counter is 0.
- Region hit for address a: en & ((a | mask) == (base | mask)). The lowest-indexed hit wins. With no hit, m_region_idx=0.
- Config writes:
  - A write updates the selected field on the next clock edge.
  - A D request in the same cycle as a write is checked against the old values.
  - If the region's lock bit is 1, the write is ignored. Lock is sticky until reset.
  - An attr write with bit7=1 sets the lock together with the other attr bits.
- Alignment check:
  - half: start[0]==0.
  - word: start[1:0]==0.
  - byte: always aligned.
- Fault evaluation in D, first true condition wins:
  1. Region cross (start[top4] != end[top4]) -> misaligned, mscause 2.
  2. Side-effect region and unaligned -> misaligned, mscause 1.
  3. Start or end address has no region hit -> access, mscause 3.
  4. Load without R, or store without W, in either the start or the end region -> access, mscause 4.
  5. Otherwise no fault, mscause 0.
- Both fault bits, and mscause, are forced to 0 when d_dma=1 or d_valid=0.
- m_sideeffect = start-region side-effect bit & (d_load | d_store) & d_valid.
- Latency: exactly 1 cycle. M registers load D results when ~m_stall.
- Stall: when m_stall=1, all M outputs hold their values and d_ready=0. D inputs presented during a stall are not registered.
- A request with d_valid=0 loads m_valid=0.
- Capture record:
  - On a cycle where m_valid & (m_access_fault | m_misaligned_fault) & ~m_stall & ~fault_valid, capture the M address and mscause (M holds start address internally) and set fault_valid.
  - Later faults do not overwrite the record.
  - fault_clr clears fault_valid. If fault_clr and a qualifying fault occur in the same cycle, the new fault is captured (fault_valid stays 1 with the new data).
- Reset asserted mid-operation clears everything asynchronously. The first request after deassertion sees all regions disabled, so it takes access fault mscause 3.

Optional Feature:
- Macro: EL2_ADDRCHECK_ERRCNT_EN.
- When defined:
  - Adds output err_cnt [CNT_WIDTH-1:0] and input err_cnt_clr.
  - err_cnt increments by 1 on each fault that qualifies for capture (including when fault_valid is already 1) and saturates at all-ones.
  - err_cnt_clr zeroes it; clear beats a simultaneous increment.
- When undefined: neither port exists and there is no counter logic.

Test Plan:
- Region 0 programmed base=0x2000_0000, mask=0x0FFF_FFFF, attr=0x07. Word load at 0x2000_0010 -> next cycle m_valid=1, no fault, m_region_idx=0, m_sideeffect=0.
- Region 0 attr=0x03 (read-only). Store to 0x2000_0000 -> m_access_fault=1, m_mscause=4. fault_valid=1, fault_addr=0x2000_0000, fault_cause=4.
- Region 1 base=0xD000_0000, mask=0x0FFF_FFFF, attr=0x0F. Half load at 0xD000_0001 -> m_misaligned_fault=1, mscause=1. Same access with d_dma=1 -> no fault.
- Word load with start=0x2FFF_FFFE, end=0x3000_0001 -> misaligned, mscause=2. Load to 0x5000_0000 with no region programmed -> access fault, mscause=3; fault_cause is still 2, from the first capture.
- Region 2 attr written 0x83, then base written 0x4000_0000 -> base stays 0. Assert m_stall for 3 cycles -> M outputs frozen, d_ready=0. fault_clr coincident with a new fault -> fault_valid stays 1 with the new address.
- With EL2_ADDRCHECK_ERRCNT_EN and CNT_WIDTH=2: 5 faults -> err_cnt saturates at 3. err_cnt_clr coincident with a fault -> err_cnt=0.

Source files
------------

// File: rtl/el2_lsu_addrcheck_prog.sv
// rtl/el2_lsu_addrcheck_prog.sv - programmable region checker for LSU D-stage requests, verdict registered into M
// Optional saturating fault counter (err_cnt/err_cnt_clr) is built when EL2_ADDRCHECK_ERRCNT_EN is defined.
module el2_lsu_addrcheck_prog #(
  parameter int NUM_REGIONS = 8,
  parameter int ADDR_WIDTH  = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  cfg_wr_en,
  input  logic [3:0]            cfg_idx,
  input  logic [1:0]            cfg_sel,
  input  logic [ADDR_WIDTH-1:0] cfg_wdata,
  input  logic                  d_valid,
  output logic                  d_ready,
  input  logic [ADDR_WIDTH-1:0] d_start_addr,
  input  logic [ADDR_WIDTH-1:0] d_end_addr,
  input  logic [1:0]            d_size,
  input  logic                  d_load,
  input  logic                  d_store,
  input  logic                  d_dma,
  input  logic                  m_stall,
  output logic                  m_valid,
  output logic                  m_access_fault,
  output logic                  m_misaligned_fault,
  output logic [3:0]            m_mscause,
  output logic                  m_sideeffect,
  output logic [3:0]            m_region_idx,
  output logic                  fault_valid,
  output logic [ADDR_WIDTH-1:0] fault_addr,
  output logic [3:0]            fault_cause,
`ifdef EL2_ADDRCHECK_ERRCNT_EN
  input  logic                  err_cnt_clr,
  output logic [CNT_WIDTH-1:0]  err_cnt,
`endif
  input  logic                  fault_clr
);

  logic [ADDR_WIDTH-1:0]  rg_base [NUM_REGIONS];
  logic [ADDR_WIDTH-1:0]  rg_mask [NUM_REGIONS];
  logic [3:0]             rg_attr [NUM_REGIONS];
  logic [NUM_REGIONS-1:0] rg_lock;

  // attr bits: [0] enable, [1] read, [2] write, [3] side-effect; lock kept separately
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int r = 0; r < NUM_REGIONS; r++) begin
        rg_base[r] <= '0;
        rg_mask[r] <= '0;
        rg_attr[r] <= '0;
      end
      rg_lock <= '0;
    end else if (cfg_wr_en) begin
      for (int r = 0; r < NUM_REGIONS; r++) begin
        if ((cfg_idx == r[3:0]) && !rg_lock[r]) begin
          case (cfg_sel)
            2'd0: rg_base[r] <= cfg_wdata;
            2'd1: rg_mask[r] <= cfg_wdata;
            2'd2: begin
              rg_attr[r] <= cfg_wdata[3:0];
              rg_lock[r] <= cfg_wdata[7];
            end
            default: ;
          endcase
        end
      end
    end
  end

  logic       s_hit, e_hit;
  logic [3:0] s_idx;
  logic [3:0] s_attr, e_attr;

  // Descending scan so the lowest-indexed hit is the one left standing.
  always_comb begin
    s_hit  = 1'b0;
    e_hit  = 1'b0;
    s_idx  = '0;
    s_attr = '0;
    e_attr = '0;
    for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
      if (rg_attr[r][0] && ((d_start_addr | rg_mask[r]) == (rg_base[r] | rg_mask[r]))) begin
        s_hit  = 1'b1;
        s_idx  = r[3:0];
        s_attr = rg_attr[r];
      end
      if (rg_attr[r][0] && ((d_end_addr | rg_mask[r]) == (rg_base[r] | rg_mask[r]))) begin
        e_hit  = 1'b1;
        e_attr = rg_attr[r];
      end
    end
  end

  logic       aligned;
  logic       d_acc, d_mis;
  logic [3:0] d_cause;

  always_comb begin
    aligned = 1'b1;
    d_acc   = 1'b0;
    d_mis   = 1'b0;
    d_cause = 4'd0;
    case (d_size)
      2'd0:    aligned = 1'b1;
      2'd1:    aligned = ~d_start_addr[0];
      default: aligned = (d_start_addr[1:0] == 2'b00);
    endcase
    if (d_start_addr[ADDR_WIDTH-1 -: 4] != d_end_addr[ADDR_WIDTH-1 -: 4]) begin
      d_mis   = 1'b1;
      d_cause = 4'd2;
    end else if (s_attr[3] && !aligned) begin
      d_mis   = 1'b1;
      d_cause = 4'd1;
    end else if (!s_hit || !e_hit) begin
      d_acc   = 1'b1;
      d_cause = 4'd3;
    end else if ((d_load && !(s_attr[1] && e_attr[1])) || (d_store && !(s_attr[2] && e_attr[2]))) begin
      d_acc   = 1'b1;
      d_cause = 4'd4;
    end
    if (!d_valid || d_dma) begin
      d_acc   = 1'b0;
      d_mis   = 1'b0;
      d_cause = 4'd0;
    end
  end

  logic [ADDR_WIDTH-1:0] m_addr;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      m_valid            <= 1'b0;
      m_access_fault     <= 1'b0;
      m_misaligned_fault <= 1'b0;
      m_mscause          <= '0;
      m_sideeffect       <= 1'b0;
      m_region_idx       <= '0;
      m_addr             <= '0;
    end else if (!m_stall) begin
      m_valid            <= d_valid;
      m_access_fault     <= d_acc;
      m_misaligned_fault <= d_mis;
      m_mscause          <= d_cause;
      m_sideeffect       <= s_attr[3] & (d_load | d_store) & d_valid;
      m_region_idx       <= s_idx;
      m_addr             <= d_start_addr;
    end
  end

  assign d_ready = ~m_stall;

  logic fault_qual;
  assign fault_qual = m_valid & (m_access_fault | m_misaligned_fault) & ~m_stall;

  // A clear in the same cycle as a new fault frees the record for that fault.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      fault_valid <= 1'b0;
      fault_addr  <= '0;
      fault_cause <= '0;
    end else if (fault_qual && (!fault_valid || fault_clr)) begin
      fault_valid <= 1'b1;
      fault_addr  <= m_addr;
      fault_cause <= m_mscause;
    end else if (fault_clr) begin
      fault_valid <= 1'b0;
    end
  end

`ifdef EL2_ADDRCHECK_ERRCNT_EN
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      err_cnt <= '0;
    end else if (err_cnt_clr) begin
      err_cnt <= '0;
    end else if (fault_qual && !(&err_cnt)) begin
      err_cnt <= err_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end
`endif

endmodule

// File: tb/tb_el2_lsu_addrcheck_prog.sv
// tb/tb_el2_lsu_addrcheck_prog.sv - directed and random checks of el2_lsu_addrcheck_prog against a rule-level model
module tb_el2_lsu_addrcheck_prog;
`ifdef EL2_ADDRCHECK_ERRCNT_EN
  localparam int CW = 2;
`else
  localparam int CW = 16;
`endif
  localparam int NR = 8;

  logic        clk, rst_l;
  logic        cfg_wr_en;
  logic [3:0]  cfg_idx;
  logic [1:0]  cfg_sel;
  logic [31:0] cfg_wdata;
  logic        d_valid, d_ready;
  logic [31:0] d_start_addr, d_end_addr;
  logic [1:0]  d_size;
  logic        d_load, d_store, d_dma, m_stall;
  logic        m_valid, m_access_fault, m_misaligned_fault, m_sideeffect;
  logic [3:0]  m_mscause, m_region_idx;
  logic        fault_valid;
  logic [31:0] fault_addr;
  logic [3:0]  fault_cause;
  logic        fault_clr;
  logic        err_cnt_clr;
  logic [CW-1:0] err_cnt;

  el2_lsu_addrcheck_prog #(.NUM_REGIONS(NR), .ADDR_WIDTH(32), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_l(rst_l),
    .cfg_wr_en(cfg_wr_en), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
    .d_valid(d_valid), .d_ready(d_ready), .d_start_addr(d_start_addr), .d_end_addr(d_end_addr),
    .d_size(d_size), .d_load(d_load), .d_store(d_store), .d_dma(d_dma), .m_stall(m_stall),
    .m_valid(m_valid), .m_access_fault(m_access_fault), .m_misaligned_fault(m_misaligned_fault),
    .m_mscause(m_mscause), .m_sideeffect(m_sideeffect), .m_region_idx(m_region_idx),
    .fault_valid(fault_valid), .fault_addr(fault_addr), .fault_cause(fault_cause),
`ifdef EL2_ADDRCHECK_ERRCNT_EN
    .err_cnt_clr(err_cnt_clr), .err_cnt(err_cnt),
`endif
    .fault_clr(fault_clr)
  );

`ifndef EL2_ADDRCHECK_ERRCNT_EN
  assign err_cnt = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: region table plus the expected M stage and capture record.
  logic [31:0] mb [NR];
  logic [31:0] mm [NR];
  logic [7:0]  ma [NR];
  logic        e_valid, e_af, e_mf, e_se;
  logic [3:0]  e_cause, e_idx;
  logic [31:0] e_addr;
  logic        f_valid;
  logic [31:0] f_addr;
  logic [3:0]  f_cause;
  int unsigned e_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      mb[i] = '0; mm[i] = '0; ma[i] = '0;
    end
    e_valid = 0; e_af = 0; e_mf = 0; e_se = 0; e_cause = 0; e_idx = 0; e_addr = 0;
    f_valid = 0; f_addr = 0; f_cause = 0; e_cnt = 0;
  endtask

  function automatic int lookup(input logic [31:0] a);
    for (int i = 0; i < NR; i++)
      if (ma[i][0] && ((a | mm[i]) == (mb[i] | mm[i]))) return i;
    return -1;
  endfunction

  task automatic check_all();
    chk("d_ready", d_ready, !m_stall);
    chk("m_valid", m_valid, e_valid);
    chk("m_access_fault", m_access_fault, e_af);
    chk("m_misaligned_fault", m_misaligned_fault, e_mf);
    chk("m_mscause", m_mscause, e_cause);
    chk("m_sideeffect", m_sideeffect, e_se);
    chk("m_region_idx", m_region_idx, e_idx);
    chk("fault_valid", fault_valid, f_valid);
    chk("fault_addr", fault_addr, f_addr);
    chk("fault_cause", fault_cause, f_cause);
`ifdef EL2_ADDRCHECK_ERRCNT_EN
    chk("err_cnt", err_cnt, e_cnt);
`endif
  endtask

  task automatic tick();
    int si, ei, ci;
    logic [7:0] sa, ea;
    logic qual, aligned, n_af, n_mf;
    logic [3:0] n_cause;
    qual = e_valid & (e_af | e_mf) & ~m_stall;
    if (qual && (!f_valid || fault_clr)) begin
      f_valid = 1; f_addr = e_addr; f_cause = e_cause;
    end else if (fault_clr) f_valid = 0;
    if (err_cnt_clr) e_cnt = 0;
    else if (qual && e_cnt < (1 << CW) - 1) e_cnt++;
    si = lookup(d_start_addr);
    ei = lookup(d_end_addr);
    sa = (si >= 0) ? ma[si] : 8'h0;
    ea = (ei >= 0) ? ma[ei] : 8'h0;
    aligned = (d_size == 0) || (d_size == 1 && d_start_addr[0] == 0) ||
              (d_size >= 2 && d_start_addr % 4 == 0);
    n_af = 0; n_mf = 0; n_cause = 0;
    if (d_start_addr[31:28] != d_end_addr[31:28]) begin n_mf = 1; n_cause = 2; end
    else if (sa[3] && !aligned) begin n_mf = 1; n_cause = 1; end
    else if (si < 0 || ei < 0) begin n_af = 1; n_cause = 3; end
    else if ((d_load && (!sa[1] || !ea[1])) || (d_store && (!sa[2] || !ea[2]))) begin n_af = 1; n_cause = 4; end
    if (!d_valid || d_dma) begin n_af = 0; n_mf = 0; n_cause = 0; end
    if (!m_stall) begin
      e_valid = d_valid; e_af = n_af; e_mf = n_mf; e_cause = n_cause;
      e_se = sa[3] & (d_load | d_store) & d_valid;
      e_idx = (si >= 0) ? 4'(si) : 4'd0;
      e_addr = d_start_addr;
    end
    ci = int'(cfg_idx);
    if (cfg_wr_en && ci < NR && !ma[ci][7]) begin
      if (cfg_sel == 0) mb[ci] = cfg_wdata;
      else if (cfg_sel == 1) mm[ci] = cfg_wdata;
      else if (cfg_sel == 2) ma[ci] = cfg_wdata[7:0];
    end
    @(posedge clk);
    #1;
    cfg_wr_en = 0; fault_clr = 0; err_cnt_clr = 0;
    check_all();
  endtask

  task automatic cfg(input logic [3:0] i, input logic [1:0] s, input logic [31:0] d);
    cfg_wr_en = 1; cfg_idx = i; cfg_sel = s; cfg_wdata = d;
    tick();
  endtask

  task automatic req2(input logic [31:0] s, input logic [31:0] e, input logic [1:0] sz,
                      input logic ld, input logic st);
    d_valid = 1; d_start_addr = s; d_end_addr = e; d_size = sz; d_load = ld; d_store = st;
  endtask

  task automatic req(input logic [31:0] s, input logic [1:0] sz, input logic ld, input logic st);
    req2(s, s + ((sz == 0) ? 32'd0 : (sz == 1) ? 32'd1 : 32'd3), sz, ld, st);
  endtask

  task automatic idle();
    d_valid = 0; d_load = 0; d_store = 0;
  endtask

  initial begin
    rst_l = 0; cfg_wr_en = 0; cfg_idx = 0; cfg_sel = 0; cfg_wdata = 0;
    d_valid = 0; d_start_addr = 0; d_end_addr = 0; d_size = 0; d_load = 0; d_store = 0;
    d_dma = 0; m_stall = 0; fault_clr = 0; err_cnt_clr = 0;
    model_reset();
    #12;
    check_all();
    @(posedge clk); #1;
    rst_l = 1;

    cfg(0, 0, 32'h2000_0000);
    cfg(0, 1, 32'h0FFF_FFFF);
    cfg(0, 2, 32'h07);
    req(32'h2000_0010, 2, 1, 0); tick();
    chk("tp1_valid", m_valid, 1);
    chk("tp1_nofault", {m_access_fault, m_misaligned_fault}, 0);

    // Store alongside a read-only attr write is judged against the old attr.
    cfg_wr_en = 1; cfg_idx = 0; cfg_sel = 2; cfg_wdata = 32'h03;
    req(32'h2000_0000, 2, 0, 1); tick();
    chk("old_cfg_used", m_access_fault, 0);
    tick();
    chk("ro_store_af", m_access_fault, 1);
    chk("ro_store_cause", m_mscause, 4);
    idle(); tick();
    chk("cap_addr", fault_addr, 32'h2000_0000);
    chk("cap_cause", fault_cause, 4);
    fault_clr = 1; tick();
    chk("clr_valid", fault_valid, 0);

    cfg(1, 0, 32'hD000_0000);
    cfg(1, 1, 32'h0FFF_FFFF);
    cfg(1, 2, 32'h0F);
    req(32'hD000_0001, 1, 1, 0); tick();
    chk("se_misal", m_misaligned_fault, 1);
    chk("se_cause", m_mscause, 1);
    d_dma = 1; tick(); d_dma = 0;
    chk("dma_nofault", {m_misaligned_fault, m_mscause}, 0);
    idle(); fault_clr = 1; tick();

    req2(32'h2FFF_FFFE, 32'h3000_0001, 2, 1, 0); tick();
    chk("cross_cause", m_mscause, 2);
    req(32'h5000_0000, 2, 1, 0); tick();
    chk("nohit_cause", m_mscause, 3);
    idle(); tick();
    chk("first_cap_kept", fault_cause, 2);

    cfg(2, 2, 32'h83);
    cfg(2, 0, 32'h4000_0000);
    req(32'h0000_0000, 2, 1, 0); tick();
    chk("lock_base_kept_idx", m_region_idx, 2);
    req(32'h4000_0000, 2, 1, 0); tick();
    chk("lock_base_miss", m_mscause, 3);

    req(32'h2000_0010, 2, 1, 0); tick();
    m_stall = 1;
    for (int i = 0; i < 3; i++) begin
      req(32'h5000_0000 + 32'(i), 0, 0, 1); tick();
      chk("stall_ready", d_ready, 0);
      chk("stall_hold", m_access_fault, 0);
    end
    m_stall = 0;

    req(32'h6000_0000, 2, 1, 0); tick();
    idle(); fault_clr = 1; tick();
    chk("clr_vs_new_valid", fault_valid, 1);
    chk("clr_vs_new_addr", fault_addr, 32'h6000_0000);

`ifdef EL2_ADDRCHECK_ERRCNT_EN
    err_cnt_clr = 1; req(32'h5000_0000, 2, 1, 0); tick();
    repeat (5) tick();
    chk("cnt_sat", err_cnt, 3);
    err_cnt_clr = 1; tick();
    chk("cnt_clr_wins", err_cnt, 0);
    idle(); tick();
`endif

    @(posedge clk); #3;
    rst_l = 0; #1;
    model_reset();
    check_all();
    #10;
    rst_l = 1;
    req(32'h2000_0010, 2, 1, 0); tick();
    chk("post_reset_cause", m_mscause, 3);

    for (int n = 0; n < 600; n++) begin
      logic [31:0] s;
      logic [1:0] sz;
      cfg_wr_en = ($urandom_range(0, 2) == 0);
      cfg_idx = 4'($urandom_range(0, 15));
      cfg_sel = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: cfg_wdata = {4'($urandom_range(0, 7)), 28'h0};
        1: cfg_wdata = 32'h0FFF_FFFF;
        2: cfg_wdata = {4'($urandom_range(0, 7)), 4'($urandom), 24'h0};
        default: cfg_wdata = $urandom;
      endcase
      if (cfg_sel == 2) cfg_wdata = {24'h0, ($urandom_range(0, 15) == 0), 3'b0, 4'($urandom)};
      sz = 2'($urandom_range(0, 3));
      s = {4'($urandom_range(0, 7)), 28'($urandom)};
      if ($urandom_range(0, 7) == 0) s[27:0] = 28'hFFF_FFFE;
      req(s, sz, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 7) == 0) d_end_addr = $urandom;
      d_valid = ($urandom_range(0, 3) != 0);
      d_dma = ($urandom_range(0, 7) == 0);
      m_stall = ($urandom_range(0, 3) == 0);
      fault_clr = ($urandom_range(0, 7) == 0);
      err_cnt_clr = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
